// File: rtl/sample_mixer_pkg.sv
// Shared types and helpers for the N-channel sample mixer.
package sample_mixer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_t;

  // Accumulator width large enough that summing all channels cannot overflow.
  function automatic int unsigned acc_width(input int unsigned width, input int unsigned num_ch);
    return width + $clog2(num_ch) + 32'd1;
  endfunction

  function automatic int unsigned fade_max(input int unsigned fade_log2);
    return 32'd1 << fade_log2;
  endfunction

  // Clamp a sign-extended value to the signed range of a width-bit sample.
  function automatic logic signed [31:0] saturate(input logic signed [31:0] x,
                                                  input int unsigned width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 32'd1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 32'd1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/sample_mixer_channel.sv
// One mixer channel: latest-sample hold, per-tick snapshot and fade-gain ramp.
module mixer_channel
  import sample_mixer_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned FADE_LOG2 = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     sample,
  input  logic                 ready,
  input  logic                 enable,
  input  logic                 tick_accept,
  output logic [WIDTH-1:0]     snap,
  output logic [FADE_LOG2:0]   gsnap,
  output logic [FADE_LOG2:0]   gain
);

  localparam int unsigned GAIN_W = FADE_LOG2 + 1;
  localparam logic [GAIN_W-1:0] GAIN_MAX = GAIN_W'(fade_max(FADE_LOG2));

  logic [WIDTH-1:0] hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold  <= '0;
      snap  <= '0;
      gsnap <= '0;
      gain  <= '0;
    end else begin
      if (ready) hold <= sample;
      // Snapshot uses the pre-update gain, so the ramp lags the tick by one.
      if (tick_accept) begin
        snap  <= hold;
        gsnap <= gain;
        if (enable && (gain != GAIN_MAX))
          gain <= gain + GAIN_W'(1);
        else if (!enable && (gain != '0))
          gain <= gain - GAIN_W'(1);
      end
    end
  end

endmodule

// File: rtl/sample_mixer.sv
// N-channel faded sample mixer: one channel accumulated per cycle, saturated on output.
module sample_mixer
  import sample_mixer_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned FADE_LOG2 = 4,
  parameter int unsigned ATT_W     = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      generate_next_sample,
  input  logic [NUM_CH*WIDTH-1:0]   ch_sample,
  input  logic [NUM_CH-1:0]         ch_ready,
  input  logic [NUM_CH-1:0]         ch_enable,
  input  logic [NUM_CH*ATT_W-1:0]   ch_atten,
  output logic [WIDTH-1:0]          sample_out,
  output logic                      sample_ready,
  output logic                      busy,
  output logic                      active,
  output logic                      overrun
);

  localparam int unsigned ACC_W  = acc_width(WIDTH, NUM_CH);
  localparam int unsigned GAIN_W = FADE_LOG2 + 1;
  localparam int unsigned PROD_W = WIDTH + GAIN_W + 1;
  localparam int unsigned IDX_W  = $clog2(NUM_CH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  state_t                   state;
  logic [IDX_W-1:0]         ch_idx;
  logic signed [ACC_W-1:0]  acc;

  logic [WIDTH-1:0]         snap  [NUM_CH];
  logic [GAIN_W-1:0]        gsnap [NUM_CH];
  logic [GAIN_W-1:0]        gain  [NUM_CH];
  logic [ATT_W-1:0]         atten [NUM_CH];
  logic [NUM_CH-1:0]        gain_nz;

  logic                     tick_accept_c;
  logic signed [PROD_W-1:0] snap_ext_c;
  logic signed [PROD_W-1:0] gain_ext_c;
  logic signed [PROD_W-1:0] prod_c;
  logic signed [PROD_W-1:0] term_c;
  logic signed [ACC_W-1:0]  sum_c;
  logic [WIDTH-1:0]         sat_c;

  assign tick_accept_c = generate_next_sample && (state != ACCUM);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    mixer_channel #(
      .WIDTH     (WIDTH),
      .FADE_LOG2 (FADE_LOG2)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .sample      (ch_sample[i*WIDTH +: WIDTH]),
      .ready       (ch_ready[i]),
      .enable      (ch_enable[i]),
      .tick_accept (tick_accept_c),
      .snap        (snap[i]),
      .gsnap       (gsnap[i]),
      .gain        (gain[i])
    );
    assign atten[i]   = ch_atten[i*ATT_W +: ATT_W];
    assign gain_nz[i] = |gain[i];
  end

  // Faded, attenuated contribution of the channel selected this cycle.
  always_comb begin
    snap_ext_c = PROD_W'($signed(snap[ch_idx]));
    gain_ext_c = $signed(PROD_W'(gsnap[ch_idx]));
    prod_c     = snap_ext_c * gain_ext_c;
    term_c     = (prod_c >>> FADE_LOG2) >>> atten[ch_idx];
    sum_c      = acc + ACC_W'(term_c);
    sat_c      = WIDTH'(saturate(32'(acc), WIDTH));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      ch_idx       <= '0;
      acc          <= '0;
      sample_out   <= '0;
      sample_ready <= 1'b0;
      busy         <= 1'b0;
      active       <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_ready <= 1'b0;
      overrun      <= 1'b0;
      active       <= |gain_nz;
      case (state)
        IDLE: begin
          if (tick_accept_c) begin
            acc    <= '0;
            ch_idx <= '0;
            busy   <= 1'b1;
            state  <= ACCUM;
          end
        end
        ACCUM: begin
          acc     <= sum_c;
          overrun <= generate_next_sample;
          if (ch_idx == LAST_IDX) begin
            state <= OUT;
          end else begin
            ch_idx <= ch_idx + IDX_W'(1);
          end
        end
        OUT: begin
          sample_out   <= sat_c;
          sample_ready <= 1'b1;
          // A tick landing here starts the next mix without a gap.
          if (tick_accept_c) begin
            acc    <= '0;
            ch_idx <= '0;
            busy   <= 1'b1;
            state  <= ACCUM;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
